apb_master_bridge: RTL

//   Synthesisable APB3 master: queues read/write commands from a valid/ready

---
 rtl/apb_master_bridge.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/apb_master_bridge.sv
// APB3 master: buffers valid/ready commands in a small FIFO and runs each as one
// SETUP/ACCESS transfer. Define APB_MST_TIMEOUT_EN to abort stalled ACCESS phases.
module apb_master_bridge #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              pen,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic              busy,
    output logic [1:0]        dbg_state
);
    // Both ports use valid/ready: a beat moves on a rising edge where valid and
    // ready are both 1; valid and its payload hold steady until that edge.

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = 1 + ADDR_W + DATA_W;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ENT_W-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr_q, rd_ptr_q;
    logic               fifo_empty, fifo_full, push, pop;
    logic [ENT_W-1:0]   rd_entry;
    logic               psel_q, psel_d, pen_q, pen_d, pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]  paddr_q, paddr_d;
    logic [DATA_W-1:0]  pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
    logic               rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
`ifdef APB_MST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

    // Full is taken from registered pointers only, so a same-cycle pop never frees a slot.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign push       = cmd_valid && !fifo_full;
    assign rd_entry   = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= {cmd_write, cmd_addr, cmd_wdata};
    end

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        pen_d       = pen_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        pop         = 1'b0;
`ifdef APB_MST_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && (!rsp_valid_q || rsp_ready)) begin
                    pop      = 1'b1;
                    pwrite_d = rd_entry[ENT_W-1];
                    paddr_d  = rd_entry[ENT_W-2 -: ADDR_W];
                    pwdata_d = rd_entry[ENT_W-1] ? rd_entry[DATA_W-1:0] : '0;
                    psel_d   = 1'b1;
                    state_d  = S_SETUP;
`ifdef APB_MST_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            S_SETUP: begin
                pen_d   = 1'b1;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
`ifdef APB_MST_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                if (pready) begin
                    psel_d      = 1'b0;
                    pen_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pslverr;
                    rsp_rdata_d = (!pwrite_q && !pslverr) ? prdata : '0;
                    state_d     = S_IDLE;
                end
`ifdef APB_MST_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    psel_d      = 1'b0;
                    pen_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = S_IDLE;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            psel_q      <= 1'b0;
            pen_q       <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_MST_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
            psel_q      <= psel_d;
            pen_q       <= pen_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_MST_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign cmd_ready = !fifo_full;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign psel      = psel_q;
    assign pen       = pen_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign busy      = (state_q != S_IDLE) || !fifo_empty;
    assign dbg_state = state_q;

endmodule
